// File: rtl/sample_packetizer.sv
// Sample packetizer: buffers 48-bit samples in a circular FIFO and serializes
// them as 8-byte checksummed packets, interleaved with 2-byte line/frame
// marker packets, towards a byte-wide serial transmitter.
module sample_packetizer #(
  parameter int         FIFO_WIDTH = 5,
  parameter logic [7:0] SYNC_BYTE  = 8'hAA,
  parameter logic [7:0] LINE_BYTE  = 8'hB1,
  parameter logic [7:0] FRAME_BYTE = 8'hB2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic [47:0] din,
  input  logic        new_line,
  input  logic        new_frame,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  output logic        writing_done,
  output logic        new_line_done,
  output logic        new_frame_done,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int                  DEPTH     = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] DEPTH_CNT = (FIFO_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t                state_reg, state_next;

  logic [47:0]           mem [DEPTH];
  logic [47:0]           rd_data_reg;
  logic [FIFO_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_WIDTH:0]   count_reg, count_next;
  logic                  full_reg, empty_reg, overflow_reg, writing_done_reg;

  logic [47:0]           shadow_reg;
  logic [7:0]            checksum_reg;
  logic [2:0]            idx_reg;
  logic                  marker_reg, frame_kind_reg;
  logic                  line_pend_reg, frame_pend_reg;
  logic                  line_pend_next, frame_pend_next;

  logic                  wr_en, pop, rd_fetch;
  logic                  start_marker, start_frame, send_byte;
  logic                  last_byte, line_done, frame_done;
  logic [7:0]            cur_byte;

  // A sample is accepted only against the registered full flag.
  assign wr_en = din_valid & ~full_reg;

  // The buffered word is retired only after its last byte has gone out, so
  // full/empty always describe samples that are still unsent.
  assign last_byte  = (idx_reg == (marker_reg ? 3'd1 : 3'd7));
  assign pop        = (state_reg == GAP) & last_byte & ~marker_reg;
  assign line_done  = (state_reg == GAP) & last_byte & marker_reg & ~frame_kind_reg;
  assign frame_done = (state_reg == GAP) & last_byte & marker_reg & frame_kind_reg;

  // Occupancy update: a simultaneous write and retire leaves count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({wr_en, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Marker requests: repeats are absorbed; a frame supersedes a line; a new
  // request in the completion cycle re-arms the flag.
  always_comb begin
    frame_pend_next = (frame_pend_reg & ~frame_done) | new_frame;
    line_pend_next  = ((line_pend_reg & ~line_done) | new_line) & ~frame_pend_next;
  end

  // Buffer storage with registered read port (block RAM friendly, no reset).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= din;
    end
    if (rd_fetch) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Buffer pointers, count, status flags and write acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      overflow_reg     <= 1'b0;
      writing_done_reg <= 1'b0;
      line_pend_reg    <= 1'b0;
      frame_pend_reg   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_CNT);
      empty_reg        <= (count_next == '0);
      overflow_reg     <= overflow_reg | (din_valid & full_reg);
      writing_done_reg <= wr_en;
      line_pend_reg    <= line_pend_next;
      frame_pend_reg   <= frame_pend_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: markers only start on an empty buffer so they never
  // overtake buffered samples.
  always_comb begin
    state_next   = state_reg;
    rd_fetch     = 1'b0;
    start_marker = 1'b0;
    start_frame  = 1'b0;
    send_byte    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_pend_reg && empty_reg) begin
          start_marker = 1'b1;
          start_frame  = 1'b1;
          state_next   = SEND;
        end else if (line_pend_reg && empty_reg) begin
          start_marker = 1'b1;
          state_next   = SEND;
        end else if (!empty_reg) begin
          rd_fetch   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = SEND;
      SEND: begin
        if (!tx_busy) begin
          send_byte  = 1'b1;
          state_next = GAP;
        end
      end
      GAP: state_next = last_byte ? IDLE : SEND;
      default: state_next = IDLE;
    endcase
  end

  // Packet context: byte index, packet kind, shadow word and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg        <= '0;
      marker_reg     <= 1'b0;
      frame_kind_reg <= 1'b0;
      shadow_reg     <= '0;
      checksum_reg   <= '0;
    end else begin
      if (state_reg == IDLE) begin
        idx_reg        <= '0;
        marker_reg     <= start_marker;
        frame_kind_reg <= start_frame;
      end
      if (state_reg == LOAD) begin
        shadow_reg   <= rd_data_reg;
        checksum_reg <= rd_data_reg[47:40] ^ rd_data_reg[39:32] ^ rd_data_reg[31:24] ^
                        rd_data_reg[23:16] ^ rd_data_reg[15:8]  ^ rd_data_reg[7:0];
      end
      if (state_reg == GAP && !last_byte) begin
        idx_reg <= idx_reg + 3'd1;
      end
    end
  end

  // Byte selection for the current packet position.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (idx_reg != 3'd0) begin
      if (marker_reg) begin
        cur_byte = frame_kind_reg ? FRAME_BYTE : LINE_BYTE;
      end else begin
        case (idx_reg)
          3'd1:    cur_byte = shadow_reg[47:40];
          3'd2:    cur_byte = shadow_reg[39:32];
          3'd3:    cur_byte = shadow_reg[31:24];
          3'd4:    cur_byte = shadow_reg[23:16];
          3'd5:    cur_byte = shadow_reg[15:8];
          3'd6:    cur_byte = shadow_reg[7:0];
          3'd7:    cur_byte = checksum_reg;
          default: cur_byte = SYNC_BYTE;
        endcase
      end
    end
  end

  // Strobe and completion pulses follow the FSM directly, so a strobe can
  // never coincide with tx_busy, and reset silences them immediately.
  assign new_tx_data    = send_byte & ~rst;
  assign tx_data        = new_tx_data ? cur_byte : 8'h00;
  assign new_line_done  = line_done & ~rst;
  assign new_frame_done = frame_done & ~rst;
  assign writing_done   = writing_done_reg;
  assign full           = full_reg;
  assign empty          = empty_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_sample_packetizer.sv
// Directed self-checking bench for sample_packetizer.
module tb_sample_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic [47:0] din = '0;
  logic        new_line = 1'b0;
  logic        new_frame = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        writing_done;
  logic        new_line_done;
  logic        new_frame_done;
  logic        full;
  logic        empty;
  logic        overflow;

  always #5 clk = ~clk;

  sample_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .din_valid      (din_valid),
    .din            (din),
    .new_line       (new_line),
    .new_frame      (new_frame),
    .tx_busy        (tx_busy),
    .tx_data        (tx_data),
    .new_tx_data    (new_tx_data),
    .writing_done   (writing_done),
    .new_line_done  (new_line_done),
    .new_frame_done (new_frame_done),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Transmit-side monitor.
  int         cyc = 0;
  logic [7:0] byte_q[$];
  int         stamp_q[$];
  int         busy_viol = 0;
  int         b2b_viol = 0;
  int         wd_cnt = 0;
  int         ld_cnt = 0;
  int         fd_cnt = 0;
  int         ld_cyc = 0;
  logic       prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (new_tx_data) begin
      byte_q.push_back(tx_data);
      stamp_q.push_back(cyc);
      if (tx_busy) busy_viol <= busy_viol + 1;
      if (prev_strobe) b2b_viol <= b2b_viol + 1;
    end
    prev_strobe <= new_tx_data;
    if (writing_done) wd_cnt <= wd_cnt + 1;
    if (new_line_done) begin
      ld_cnt <= ld_cnt + 1;
      ld_cyc <= cyc;
    end
    if (new_frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_word(input logic [47:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int base, input int n, input int budget, input bit rnd);
    int k = 0;
    while ((byte_q.size() - base) < n && k < budget) begin
      if (rnd) tx_busy = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    tx_busy = 1'b0;
    check("bytes_received", 64'(byte_q.size() - base), 64'(n));
  endtask

  task automatic check_bytes(input string tag, input int base, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < byte_q.size())
        check(tag, 64'(byte_q[base + i]), 64'(exp[i]));
      else
        check(tag, 64'hDEAD, 64'(exp[i]));
    end
  endtask

  initial begin
    int base, wd0, ld0, fd0, bv0, bb0;
    logic [7:0] exp_q[$];

    // Reset state
    do_reset();
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_new_tx_data", 64'(new_tx_data), 64'h0);
    check("rst_writing_done", 64'(writing_done), 64'h0);
    check("rst_line_done", 64'(new_line_done), 64'h0);
    check("rst_frame_done", 64'(new_frame_done), 64'h0);
    check("rst_full", 64'(full), 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_overflow", 64'(overflow), 64'h0);

    // Single sample, idle transmitter
    base = byte_q.size();
    bb0  = b2b_viol;
    write_word(48'h0102_0304_0506);
    check("wdone_latency", 64'(writing_done), 64'h1);
    step();
    check("wdone_one_cycle", 64'(writing_done), 64'h0);
    wait_bytes(base, 8, 100, 1'b0);
    exp_q = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    check_bytes("single_pkt", base, exp_q);
    for (int k = 1; k < 8; k++)
      check("strobe_spacing", 64'(stamp_q[base + k] - stamp_q[base + k - 1]), 64'd2);
    step();
    step();
    check("single_empty_after", 64'(empty), 64'h1);
    check("single_no_b2b", 64'(b2b_viol - bb0), 64'd0);

    // Overflow with transmitter held busy
    do_reset();
    tx_busy = 1'b1;
    wd0 = wd_cnt;
    for (int i = 0; i < 33; i++) begin
      din       = 48'(i + 100);
      din_valid = 1'b1;
      step();
      if (i == 31) begin
        check("full_after_32", 64'(full), 64'h1);
        check("no_overflow_at_32", 64'(overflow), 64'h0);
      end
    end
    din_valid = 1'b0;
    check("overflow_set", 64'(overflow), 64'h1);
    step();
    step();
    check("wdone_count_32", 64'(wd_cnt - wd0), 64'd32);
    tx_busy = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("overflow_sticky", 64'(overflow), 64'h1);
    check("not_full_after_drain", 64'(full), 64'h0);

    // Two samples then a line marker
    do_reset();
    base = byte_q.size();
    ld0  = ld_cnt;
    fd0  = fd_cnt;
    write_word(48'h1122_3344_5566);
    write_word(48'hFFEE_DDCC_BBAA);
    new_line = 1'b1;
    step();
    new_line = 1'b0;
    wait_bytes(base, 18, 300, 1'b0);
    exp_q = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
              8'hAA, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h11,
              8'hAA, 8'hB1};
    check_bytes("line_seq", base, exp_q);
    step();
    step();
    check("line_done_count", 64'(ld_cnt - ld0), 64'd1);
    check("line_frame_done_none", 64'(fd_cnt - fd0), 64'd0);
    check("line_done_latency", 64'(ld_cyc - stamp_q[base + 17]), 64'd1);

    // Simultaneous line and frame on an empty buffer
    do_reset();
    base = byte_q.size();
    ld0  = ld_cnt;
    fd0  = fd_cnt;
    new_line  = 1'b1;
    new_frame = 1'b1;
    step();
    new_line  = 1'b0;
    new_frame = 1'b0;
    wait_bytes(base, 2, 50, 1'b0);
    exp_q = '{8'hAA, 8'hB2};
    check_bytes("frame_seq", base, exp_q);
    for (int k = 0; k < 30; k++) step();
    check("frame_done_count", 64'(fd_cnt - fd0), 64'd1);
    check("frame_line_done_none", 64'(ld_cnt - ld0), 64'd0);
    check("frame_no_extra_bytes", 64'(byte_q.size() - base), 64'd2);

    // Randomly toggled busy
    do_reset();
    base = byte_q.size();
    bv0  = busy_viol;
    bb0  = b2b_viol;
    write_word(48'h0F1E_2D3C_4B5A);
    write_word(48'h8000_0000_0001);
    write_word(48'h1234_5678_9ABC);
    wait_bytes(base, 24, 2000, 1'b1);
    exp_q = '{8'hAA, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h11,
              8'hAA, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h81,
              8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};
    check_bytes("busy_seq", base, exp_q);
    check("busy_strobe_viol", 64'(busy_viol - bv0), 64'd0);
    check("busy_b2b_viol", 64'(b2b_viol - bb0), 64'd0);

    // Reset in the middle of a packet
    do_reset();
    base = byte_q.size();
    write_word(48'hDEAD_BEEF_0123);
    write_word(48'h0000_1111_2222);
    for (int k = 0; k < 100 && (byte_q.size() - base) < 3; k++) begin
      @(negedge clk);
      #1;
    end
    check("mid_bytes_before_rst", 64'(byte_q.size() - base), 64'd3);
    rst = 1'b1;
    step();
    check("mid_tx_data", 64'(tx_data), 64'h00);
    check("mid_new_tx_data", 64'(new_tx_data), 64'h0);
    check("mid_writing_done", 64'(writing_done), 64'h0);
    check("mid_line_done", 64'(new_line_done), 64'h0);
    check("mid_frame_done", 64'(new_frame_done), 64'h0);
    check("mid_full", 64'(full), 64'h0);
    check("mid_empty", 64'(empty), 64'h1);
    check("mid_overflow", 64'(overflow), 64'h0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("mid_no_more_bytes", 64'(byte_q.size() - base), 64'd3);
    check("mid_empty_after", 64'(empty), 64'h1);
    exp_q = '{8'hAA, 8'hDE, 8'hAD};
    check_bytes("mid_prefix", base, exp_q);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sample_packetizer.md
SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 5: the buffer depth is 2^FIFO_WIDTH 48-bit words.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hAA: the first byte of every packet.
REQ-003 The block SHALL have parameters LINE_BYTE (default 8'hB1) and FRAME_BYTE (default 8'hB2): the marker packet payloads.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset, with ports clk (in, 1) and rst (in, 1); all state changes on the rising edge of clk.
REQ-005 The block SHALL have port din_valid (in, 1): one-cycle write strobe from the TDC control stage.
REQ-006 The block SHALL have port din (in, 48): sample word, valid while din_valid is high.
REQ-007 The block SHALL have ports new_line and new_frame (in, 1 each): one-cycle marker requests from MEMS control.
REQ-008 The block SHALL have port tx_busy (in, 1): serial transmitter busy.
REQ-009 The block SHALL have ports tx_data (out, 8) and new_tx_data (out, 1): byte to the serial transmitter and its one-cycle strobe.
REQ-010 The block SHALL have port writing_done (out, 1): one-cycle pulse acknowledging an accepted sample.
REQ-011 The block SHALL have ports new_line_done and new_frame_done (out, 1 each): one-cycle marker-sent pulses.
REQ-012 The block SHALL have ports full, empty and overflow (out, 1 each): buffer status; overflow is sticky.

Function
REQ-013 The block SHALL buffer samples in a circular FIFO with FIFO_WIDTH-bit read/write pointers and a (FIFO_WIDTH+1)-bit count; pointers wrap from 2^FIFO_WIDTH-1 to 0.
REQ-014 full and empty SHALL be registered flags (count==2^FIFO_WIDTH, count==0), valid from the cycle after the count changes.
REQ-015 A write SHALL be accepted when din_valid=1 and the registered full=0; writing_done then pulses high exactly one cycle later.
REQ-016 On din_valid=1 with full=1 the word SHALL be dropped, overflow set to 1 until reset, and no writing_done pulse issued, even if a read occurs in the same cycle.
REQ-017 A simultaneous accepted write and FIFO read SHALL leave count unchanged.
REQ-018 new_line and new_frame SHALL each set a pending flag; a repeated request while pending SHALL be absorbed; a pending frame SHALL clear any pending line (a frame implies a line).
REQ-019 The FSM SHALL use states IDLE, LOAD, SEND and GAP.
REQ-020 In IDLE, when frame is pending and empty=1, the FSM SHALL start a frame marker packet; else when line is pending and empty=1, a line marker packet; else when empty=0, go to LOAD.
REQ-021 Marker packets therefore SHALL never overtake samples already buffered.
REQ-022 LOAD SHALL read one word (one-cycle read latency) into a 48-bit shadow register and compute checksum = XOR of its six bytes, then go to SEND.
REQ-023 A data packet SHALL be 8 bytes, in order: SYNC_BYTE, din[47:40], [39:32], [31:24], [23:16], [15:8], [7:0], checksum.
REQ-024 A marker packet SHALL be 2 bytes: SYNC_BYTE, then LINE_BYTE or FRAME_BYTE.
REQ-025 In SEND, when tx_busy=0 the block SHALL drive tx_data and pulse new_tx_data for one cycle, then enter GAP for exactly one cycle without sampling tx_busy, then return to SEND (more bytes) or IDLE (packet complete).
REQ-026 new_tx_data SHALL never assert while tx_busy=1, and SHALL never assert on two consecutive cycles.
REQ-027 new_line_done or new_frame_done SHALL pulse one cycle in the GAP cycle following the final marker byte, and the matching pending flag SHALL clear in that same cycle.
REQ-028 A request arriving during transmission of its own marker packet SHALL re-arm pending and produce a second packet.
REQ-029 Samples SHALL continue to be accepted in every FSM state.

Reset
REQ-030 On rst=1 the block SHALL set: pointers, count, pending flags, shadow and checksum to 0; FSM to IDLE; tx_data=0, new_tx_data=0, writing_done=0, new_line_done=0, new_frame_done=0, full=0, empty=1, overflow=0.
REQ-031 rst asserted mid-packet SHALL abort the packet without emitting further bytes; buffered data is discarded.

Verification
REQ-032 Write din=48'h0102_0304_0506 with tx_busy=0 -> writing_done one cycle later; bytes AA,01,02,03,04,05,06,07 with strobes 2 cycles apart; empty=1 afterwards.
REQ-033 Write 33 words with tx_busy held 1 (FIFO_WIDTH=5) -> full=1 after 32, 33rd dropped, overflow=1, only 32 writing_done pulses.
REQ-034 Two samples buffered, then new_line -> both 8-byte packets, then AA,B1, then new_line_done one cycle after the B1 strobe.
REQ-035 new_line and new_frame in the same cycle on empty FIFO -> only AA,B2 sent, new_frame_done pulses, new_line_done never pulses.
REQ-036 tx_busy toggled randomly -> no strobe while busy, no back-to-back strobes, byte order and checksum intact.
REQ-037 rst asserted after the third byte of a packet -> no further strobes, all outputs at REQ-030 values the next cycle.
